// File: rtl/life_scan_ctrl.sv
// Scan-chain initiator for the 4x4 life array. A start request rotates the 16-cell
// chain once, snapshots every cell into rd_data and optionally loads a new pattern.
module life_scan_ctrl #(
  parameter int unsigned GAP = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        wr_enb,
  input  logic [15:0] wr_data,
  input  logic        scan_read_val,
  output logic        scan,
  output logic        scan_write_val,
  output logic        scan_write_enb,
  output logic        busy,
  output logic        run_hold,
  output logic        done,
  output logic [15:0] rd_data
);

  // Handshake: start/wr_enb/wr_data are sampled together only while idle (busy=0);
  // requests during a scan are dropped. done pulses for one cycle and rd_data stays
  // valid from that cycle until the next done.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam bit         HAS_GAP  = (GAP > 0);
  localparam logic [7:0] GAP_LAST = HAS_GAP ? 8'(GAP - 1) : 8'd0;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  idx;
  logic [7:0]  gap_cnt;
  logic [15:0] wr_sr;
  logic [15:0] rd_sr;
  logic        wr_mode;
  logic        last_shift;

  assign last_shift = (idx == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_shift)   state_nxt = S_DONE;
        else if (HAS_GAP) state_nxt = S_GAP;
        else              state_nxt = S_SHIFT;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_SHIFT;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shift registers: the tail is captured LSB-first so cell 15 ends up in bit 15.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_sr   <= 16'd0;
      rd_sr   <= 16'd0;
      rd_data <= 16'd0;
      wr_mode <= 1'b0;
      idx     <= 4'd0;
      gap_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            wr_sr   <= wr_data;
            wr_mode <= wr_enb;
            idx     <= 4'd0;
            gap_cnt <= 8'd0;
          end
        end
        S_SHIFT: begin
          rd_sr   <= {rd_sr[14:0], scan_read_val};
          wr_sr   <= {wr_sr[14:0], 1'b0};
          gap_cnt <= 8'd0;
          if (last_shift) begin
            rd_data <= {rd_sr[14:0], scan_read_val};
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) gap_cnt <= 8'd0;
          else                     gap_cnt <= gap_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    scan           = 1'b0;
    scan_write_val = 1'b0;
    scan_write_enb = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      S_SHIFT: begin
        scan           = 1'b1;
        scan_write_val = wr_sr[15];
        scan_write_enb = wr_mode;
        busy           = 1'b1;
      end
      S_GAP: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    run_hold = busy;
  end

endmodule

// File: tb/tb_life_scan_ctrl.sv
// Bench for life_scan_ctrl: two instances (GAP=0 and GAP=2), each driving a
// behavioural 16-cell chain array; scans checked cycle by cycle against timing formulas.
module tb_life_scan_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_v   [2];
  logic        wr_enb_v  [2];
  logic [15:0] wr_data_v [2];
  logic        scan_rd_v [2];
  logic        scan_v    [2];
  logic        wv_v      [2];
  logic        we_v      [2];
  logic        busy_v    [2];
  logic        hold_v    [2];
  logic        done_v    [2];
  logic [15:0] rd_data_v [2];
  logic [15:0] arr_v     [2];
  logic [15:0] pre_val_v [2];
  logic        preload_v [2];

  int checks   = 0;
  int failures = 0;

  life_scan_ctrl #(.GAP(0)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .wr_enb(wr_enb_v[0]),
    .wr_data(wr_data_v[0]), .scan_read_val(scan_rd_v[0]), .scan(scan_v[0]),
    .scan_write_val(wv_v[0]), .scan_write_enb(we_v[0]), .busy(busy_v[0]),
    .run_hold(hold_v[0]), .done(done_v[0]), .rd_data(rd_data_v[0])
  );

  life_scan_ctrl #(.GAP(2)) u2 (
    .clk(clk), .reset(reset), .start(start_v[1]), .wr_enb(wr_enb_v[1]),
    .wr_data(wr_data_v[1]), .scan_read_val(scan_rd_v[1]), .scan(scan_v[1]),
    .scan_write_val(wv_v[1]), .scan_write_enb(we_v[1]), .busy(busy_v[1]),
    .run_hold(hold_v[1]), .done(done_v[1]), .rd_data(rd_data_v[1])
  );

  // Array chain model: on scan, cells move up one and cell 0 takes the head input.
  assign scan_rd_v[0] = arr_v[0][15];
  assign scan_rd_v[1] = arr_v[1][15];

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (preload_v[j])
        arr_v[j] <= pre_val_v[j];
      else if (scan_v[j])
        arr_v[j] <= {arr_v[j][14:0], (we_v[j] ? wv_v[j] : arr_v[j][15])};
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input int s, input string tag);
    chk({tag, " scan"}, 16'(scan_v[s]), 16'd0);
    chk({tag, " wv"}, 16'(wv_v[s]), 16'd0);
    chk({tag, " we"}, 16'(we_v[s]), 16'd0);
    chk({tag, " busy"}, 16'(busy_v[s]), 16'd0);
    chk({tag, " run_hold"}, 16'(hold_v[s]), 16'd0);
    chk({tag, " done"}, 16'(done_v[s]), 16'd0);
    chk({tag, " rd_data"}, rd_data_v[s], 16'd0);
  endtask

  task automatic preload(input int s, input logic [15:0] v);
    @(negedge clk);
    pre_val_v[s] = v;
    preload_v[s] = 1'b1;
    @(negedge clk);
    preload_v[s] = 1'b0;
  endtask

  // One full scan; start sampled at edge 0, cycle c is the cycle after edge c-1.
  task automatic run_scan(input int s, input int gap, input logic enb,
                          input logic [15:0] data, input logic [15:0] board,
                          input logic [15:0] exp_rd, input logic [15:0] exp_arr,
                          input string tag);
    int  done_cyc;
    int  i;
    bit  exp_shift;
    bit  exp_busy;
    logic [15:0] data_l;
    data_l = data;
    done_cyc = 17 + 15 * gap;
    preload(s, board);
    @(negedge clk);
    start_v[s]   = 1'b1;
    wr_enb_v[s]  = enb;
    wr_data_v[s] = data;
    @(posedge clk);
    for (int c = 1; c <= done_cyc + 1; c++) begin
      @(negedge clk);
      start_v[s]   = 1'b0;
      wr_enb_v[s]  = 1'($urandom);
      wr_data_v[s] = 16'($urandom);
      exp_shift = (c <= 1 + 15 * (gap + 1)) && (((c - 1) % (gap + 1)) == 0);
      exp_busy  = (c <= done_cyc);
      chk({tag, " scan"}, 16'(scan_v[s]), 16'(exp_shift));
      chk({tag, " busy"}, 16'(busy_v[s]), 16'(exp_busy));
      chk({tag, " run_hold"}, 16'(hold_v[s]), 16'(exp_busy));
      chk({tag, " done"}, 16'(done_v[s]), 16'(c == done_cyc));
      if (exp_shift) begin
        i = (c - 1) / (gap + 1);
        chk({tag, " we"}, 16'(we_v[s]), 16'(enb));
        chk({tag, " wv"}, 16'(wv_v[s]), 16'(data_l[15 - i]));
      end else begin
        chk({tag, " we idle"}, 16'(we_v[s]), 16'd0);
        chk({tag, " wv idle"}, 16'(wv_v[s]), 16'd0);
      end
      if (c == done_cyc) chk({tag, " rd_data"}, rd_data_v[s], exp_rd);
    end
    chk({tag, " rd_data held"}, rd_data_v[s], exp_rd);
    chk({tag, " array"}, arr_v[s], exp_arr);
  endtask

  typedef struct {
    int          s;
    int          gap;
    logic        enb;
    logic [15:0] data;
    logic [15:0] board;
    logic [15:0] exp_rd;
    logic [15:0] exp_arr;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic        enb;
    logic [15:0] data;
    logic [15:0] board;
    int          s;
    bit          e_scan;
    bit          e_busy;

    for (int j = 0; j < 2; j++) begin
      start_v[j] = 1'b0; wr_enb_v[j] = 1'b0; wr_data_v[j] = 16'd0;
      pre_val_v[j] = 16'd0; preload_v[j] = 1'b0;
    end
    reset = 1'b0;
    #22;
    chk_all_zero(0, "reset g0");
    chk_all_zero(1, "reset g2");
    @(negedge clk);
    reset = 1'b1;

    tbl[0] = '{0, 0, 1'b0, 16'h0000, 16'hA5C3, 16'hA5C3, 16'hA5C3};
    tbl[1] = '{0, 0, 1'b1, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h1234};
    tbl[2] = '{1, 2, 1'b0, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
    tbl[3] = '{1, 2, 1'b1, 16'hBEEF, 16'h0F00, 16'h0F00, 16'hBEEF};
    for (int t = 0; t < 4; t++)
      run_scan(tbl[t].s, tbl[t].gap, tbl[t].enb, tbl[t].data, tbl[t].board,
               tbl[t].exp_rd, tbl[t].exp_arr, $sformatf("tbl%0d", t));

    // Asynchronous reset during shift 7 (idx=7) with a load scan in flight.
    preload(0, 16'h5A5A);
    @(negedge clk);
    start_v[0] = 1'b1; wr_enb_v[0] = 1'b1; wr_data_v[0] = 16'hFFFF;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    chk("midreset pre scan", 16'(scan_v[0]), 16'd1);
    #2 reset = 1'b0;
    #1;
    chk_all_zero(0, "midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midreset held done", 16'(done_v[0]), 16'd0);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post reset done", 16'(done_v[0]), 16'd0);
      chk("post reset busy", 16'(busy_v[0]), 16'd0);
    end
    run_scan(0, 0, 1'b0, 16'h0000, 16'h3C96, 16'h3C96, 16'h3C96, "after reset");

    // start held high: two back-to-back scans, done at cycles 17 and 35.
    preload(0, 16'h0F0F);
    @(negedge clk);
    start_v[0] = 1'b1; wr_enb_v[0] = 1'b0; wr_data_v[0] = 16'h8001;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 36) start_v[0] = 1'b0;
      e_scan = (c >= 1 && c <= 16) || (c >= 19 && c <= 34);
      e_busy = (c >= 1 && c <= 17) || (c >= 19 && c <= 35);
      chk("held scan", 16'(scan_v[0]), 16'(e_scan));
      chk("held busy", 16'(busy_v[0]), 16'(e_busy));
      chk("held run_hold", 16'(hold_v[0]), 16'(e_busy));
      chk("held done", 16'(done_v[0]), 16'(c == 17 || c == 35));
    end
    chk("held rd_data", rd_data_v[0], 16'h0F0F);
    chk("held array", arr_v[0], 16'h0F0F);

    // Randomized scans against the reference: snapshot = old board, board = load ? data : old.
    for (int r = 0; r < 12; r++) begin
      s     = int'($urandom_range(0, 1));
      enb   = 1'($urandom);
      data  = 16'($urandom);
      board = 16'($urandom);
      run_scan(s, (s == 1) ? 2 : 0, enb, data, board, board, enb ? data : board,
               $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_scan_ctrl.md
# life_scan_ctrl

Scan-chain controller for the 4x4 life array: the initiator side of the array's serial scan port. On a `start` request it clocks the 16-cell chain through one full rotation. It captures every cell into a parallel snapshot and can optionally replace the board with a new 16-bit pattern. It sits between the board-level control logic and `life_array_4x4`, replacing the free-running `trigger & scan_enb` scan gating. It also supplies a hold signal so generation stepping is frozen while a scan is in flight.

## Interface

Parameters:
- `GAP`, default 0: idle cycles inserted between consecutive scan pulses; legal range 0..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Low forces the reset state immediately, independent of `clk`.
- `start`  in  1  request one full scan; sampled only in IDLE.
- `wr_enb`  in  1  sampled with `start`. 1 = load `wr_data` into the array; 0 = read-only (board recirculates unchanged).
- `wr_data`  in  16  new pattern; bit k = cell k, where k = row*4+col. Sampled with `start`.
- `scan_read_val`  in  1  array chain tail (current cell 15).
- `scan`  out  1  one-cycle shift strobe to the array.
- `scan_write_val`  out  1  bit entering the chain head (cell 0).
- `scan_write_enb`  out  1  1 = head takes `scan_write_val`; 0 = head takes the tail (recirculate).
- `busy`  out  1  high from the first SHIFT cycle through the DONE cycle.
- `run_hold`  out  1  equal to `busy`. Top gates stepping with `run = trigger & enb & ~run_hold`.
- `done`  out  1  one-cycle pulse; `rd_data` is valid from this cycle onward.
- `rd_data`  out  16  snapshot of the board before the scan; bit k = cell k. Held until the next DONE.

## Operation

- Array chain contract: on each cycle with `scan`=1, cell k moves to cell k+1 for k=0..14. Cell 15 leaves on `scan_read_val`, which is combinational from cell 15 before the edge. Cell 0 loads the head input.
- FSM states:
  - IDLE → SHIFT on `start`=1. This edge latches `wr_data` into shift register `wr_sr`, latches `wr_enb` into `wr_mode`, and clears `idx` and the gap counter.
  - SHIFT: lasts one cycle and asserts `scan`=1. `rd_sr <= {rd_sr[14:0], scan_read_val}`; `wr_sr <= wr_sr << 1`. If `idx`=15 → DONE. Otherwise `idx`+1, then → GAP if `GAP`>0, else stay in SHIFT.
  - GAP: holds `scan`=0 for exactly `GAP` cycles, then → SHIFT.
  - DONE: lasts one cycle, asserts `done`=1, then → IDLE.
- Output drive during SHIFT:
  - `scan_write_val` = `wr_sr[15]`, so pattern bit 15-i is written on shift i.
  - `scan_write_enb` = `wr_mode`.
  - Outside SHIFT, `scan_write_enb` and `scan_write_val` are 0.
- `rd_data <= {rd_sr[14:0], scan_read_val}` on the SHIFT(15)→DONE edge. Shift i reads cell 15-i, so `rd_data[k]` = original cell k.
- After 16 shifts the board is either restored (read-only) or equal to `wr_data` (load).
- All outputs are Moore outputs from registers or state decode; no input-to-output combinational path.
- `start` is ignored in SHIFT, GAP and DONE; there is no queueing.
- `idx` is 4 bits and never wraps within a scan.

## Timing

- Reset values: `scan`, `scan_write_val`, `scan_write_enb`, `busy`, `run_hold` and `done` are 0. `rd_data`, `rd_sr`, `wr_sr`, `idx` and the gap counter are 0. State is IDLE.
- `start` sampled high at edge 0:
  - Shift i occurs in cycle 1+i*(GAP+1).
  - `done` occurs in cycle 17+15*GAP.
  - IDLE is re-entered in cycle 18+15*GAP.
- `start` held high continuously gives back-to-back scans with a period of 18+15*GAP cycles.
- Reset asserted mid-scan: all outputs drop to 0 asynchronously and no `done` is issued. The array is left partially rotated; in Top, both blocks share `reset`, so the array clears too.

## Test plan

- Reset: drive `reset`=0 during SHIFT with `idx`=7 → all outputs 0 without a clock edge. Release and issue `start` → normal scan, `done` at cycle 17.
- Read-only, GAP=0: array preloaded with 0xA5C3, `start`=1 with `wr_enb`=0 → `scan` high in cycles 1..16, `scan_write_enb`=0, `done` in cycle 17, `rd_data`=0xA5C3, array still 0xA5C3.
- Load: array at 0xFFFF, `wr_enb`=1, `wr_data`=0x1234 → `scan_write_val` sequence over shifts 0..15 is 0,0,0,1,0,0,1,0,0,0,1,1,0,1,0,0. Result: `rd_data`=0xFFFF and array=0x1234.
- GAP=2: read-only scan of 0x0001 → `scan` pulses in cycles 1,4,...,46, `done` in cycle 47, `rd_data`=0x0001, `busy` high in cycles 1..47.
- `start` held high for 40 cycles, GAP=0 → two scans, `done` in cycles 17 and 35. A `start` seen during busy cycles 2..16 produces no extra scan.
- `run_hold` check: `run_hold` equals `busy` on every cycle of all the above scenarios.
